// File: rtl/cfg_frame_pkg.sv
// cfg_frame_pkg: shared FSM states and header field positions for the config frame writer
package cfg_frame_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_e;
   localparam int WORD_W  = 32;
   localparam int HDR_MSB = 31;
   localparam int HDR_LSB = 28;
   localparam int IDX_MSB = 4;
   localparam int IDX_LSB = 0;
   localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
endpackage

// File: rtl/frame_strobe_gen.sv
// frame_strobe_gen: registered one-hot latch enable held for STROBE_CYCLES cycles after a start pulse
module frame_strobe_gen
   import cfg_frame_pkg::*;
#(
   parameter int NUM_FRAMES    = 20,
   parameter int STROBE_CYCLES = 2
) (
   input  logic                  CLK,
   input  logic                  resetn,
   input  logic                  start_i,
   input  logic [IDX_W-1:0]      idx_i,
   output logic [NUM_FRAMES-1:0] strobe_o,
   output logic                  done_o
);
   localparam int CW = STROBE_CYCLES > 1 ? $clog2(STROBE_CYCLES) : 1;
   logic [NUM_FRAMES-1:0] strobe_q, strobe_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  active_q, active_d;
   assign strobe_o = strobe_q;
   assign done_o   = active_q && cnt_q == '0;
   // Next strobe pattern and remaining width; an out-of-range idx shifts the one out, leaving the strobe low
   always_comb begin
      strobe_d = strobe_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (start_i) begin
         strobe_d = NUM_FRAMES'(1) << idx_i;
         cnt_d    = CW'(STROBE_CYCLES - 1);
         active_d = 1'b1;
      end else if (active_q) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == '0) begin
            strobe_d = '0;
            cnt_d    = '0;
            active_d = 1'b0;
         end
      end
   end
   // Strobe register clears asynchronously so a reset mid-strobe cannot leave a partial latch write
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         strobe_q <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         strobe_q <= strobe_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end
endmodule

// File: rtl/config_frame_writer.sv
// config_frame_writer: assembles a header plus NUM_ROWS data words into a frame and strobes it into a latch column
module config_frame_writer
   import cfg_frame_pkg::*;
#(
   parameter int         NUM_ROWS      = 4,
   parameter int         NUM_FRAMES    = 20,
   parameter int         STROBE_CYCLES = 2,
   parameter logic [3:0] HDR_MARK      = 4'hA
) (
   input  logic                       CLK,
   input  logic                       resetn,
   input  logic [31:0]                s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic                       clr_err,
   output logic [WORD_W*NUM_ROWS-1:0] frame_data,
   output logic [NUM_FRAMES-1:0]      frame_strobe,
   output logic                       busy,
   output logic                       err,
   output logic [15:0]                frames_done
);
   localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
   state_e                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [RW-1:0]              row_q, row_d;
   logic [WORD_W*NUM_ROWS-1:0] data_q, data_d;
   logic                       err_q, err_d;
   logic [15:0]                done_q, done_d;
   logic                       accept, idx_ok, strobe_done;
   assign s_ready     = state_q == IDLE || state_q == LOAD;
   assign accept      = s_valid && s_ready;
   assign idx_ok      = int'(idx_q) < NUM_FRAMES;
   assign busy        = state_q != IDLE;
   assign frame_data  = data_q;
   assign err         = err_q;
   assign frames_done = done_q;
   frame_strobe_gen #(
      .NUM_FRAMES   (NUM_FRAMES),
      .STROBE_CYCLES(STROBE_CYCLES)
   ) u_strobe (
      .CLK     (CLK),
      .resetn  (resetn),
      .start_i (state_q == SETUP),
      .idx_i   (idx_q),
      .strobe_o(frame_strobe),
      .done_o  (strobe_done)
   );
   // Next state, row assembly and status; an error set in the same cycle as clr_err wins
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      row_d   = row_q;
      data_d  = data_q;
      err_d   = clr_err ? 1'b0 : err_q;
      done_d  = done_q;
      case (state_q)
         IDLE: if (accept) begin
            if (s_data[HDR_MSB:HDR_LSB] == HDR_MARK) begin
               idx_d   = s_data[IDX_MSB:IDX_LSB];
               row_d   = '0;
               state_d = LOAD;
            end else err_d = 1'b1;
         end
         LOAD: if (accept) begin
            data_d[WORD_W*int'(row_q) +: WORD_W] = s_data;
            row_d = row_q + 1'b1;
            if (row_q == RW'(NUM_ROWS - 1)) begin
               state_d = SETUP;
               if (!idx_ok) err_d = 1'b1;
            end
         end
         SETUP: state_d = STROBE;
         STROBE: if (strobe_done) begin
            state_d = HOLD;
            if (idx_ok) done_d = done_q + 1'b1;
         end
         HOLD: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // State and datapath registers
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         row_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         data_q  <= data_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_config_frame_writer.sv
// tb_config_frame_writer: randomized and directed checks against a frame-level reference model
module tb_config_frame_writer;
   localparam int NR = 4, NF = 20, SC = 2;
   logic CLK = 0, resetn = 1, s_valid = 0, clr_err = 0, rand_clr = 0, chk_en = 0;
   logic [31:0] s_data = '0;
   logic s_ready, busy, err;
   logic [NR*32-1:0] frame_data;
   logic [NF-1:0] frame_strobe;
   logic [15:0] frames_done;
   logic b_rstn = 1, b_valid = 0, b_clr = 0;
   logic [31:0] b_data = '0;
   logic b_ready, b_busy, b_err;
   logic [31:0] b_fd;
   logic [NF-1:0] b_fs;
   logic [15:0] b_done;
   int n_cmp = 0, n_bad = 0;
   always #5 CLK = ~CLK;
   config_frame_writer dut (
      .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .clr_err(clr_err), .frame_data(frame_data), .frame_strobe(frame_strobe), .busy(busy),
      .err(err), .frames_done(frames_done));
   config_frame_writer #(.NUM_ROWS(1), .STROBE_CYCLES(1)) dut1 (
      .CLK(CLK), .resetn(b_rstn), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
      .clr_err(b_clr), .frame_data(b_fd), .frame_strobe(b_fs), .busy(b_busy),
      .err(b_err), .frames_done(b_done));
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference model: m_k counts cycles since the last data word of a frame was accepted (0 = none pending)
   logic [NR*32-1:0] m_data = '0;
   logic m_err = 0, m_load = 0, m_set, m_acc, m_fin;
   logic [15:0] m_done = '0;
   logic [4:0] m_idx = '0;
   int m_rows = 0, m_k = 0;
   logic [NF-1:0] e_strobe;
   assign e_strobe = (m_k >= 2 && m_k <= SC + 1 && m_idx < NF) ? (NF'(1) << m_idx) : '0;
   always @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         m_data = '0; m_err = 0; m_load = 0; m_done = '0; m_idx = '0; m_rows = 0; m_k = 0;
      end else begin
         m_set = 0; m_fin = 0;
         m_acc = s_valid && m_k == 0;
         if (m_acc && !m_load) begin
            if (s_data[31:28] == 4'hA) begin m_load = 1; m_rows = 0; m_idx = s_data[4:0]; end
            else m_set = 1;
         end else if (m_acc) begin
            m_data[m_rows*32 +: 32] = s_data;
            m_rows++;
            if (m_rows == NR) begin m_load = 0; m_fin = 1; if (m_idx >= NF) m_set = 1; end
         end
         if (m_k != 0) begin
            m_k++;
            if (m_k == SC + 2 && m_idx < NF) m_done++;
            if (m_k == SC + 3) m_k = 0;
         end
         if (m_fin) m_k = 1;
         m_err = m_set ? 1'b1 : clr_err ? 1'b0 : m_err;
      end
   end
   always @(negedge CLK) if (chk_en) begin
      chk("frame_data", frame_data, m_data);
      chk("frame_strobe", frame_strobe, e_strobe);
      chk("s_ready", s_ready, m_k == 0);
      chk("busy", busy, m_load || m_k != 0);
      chk("err", err, m_err);
      chk("frames_done", frames_done, m_done);
   end
   always @(negedge CLK) if (rand_clr) clr_err = $urandom_range(0, 7) == 0;
   task automatic put(input logic [31:0] w);
      int t;
      t = 0; s_valid = 1; s_data = w;
      while (s_ready !== 1'b1 && t < 50) begin @(negedge CLK); t++; end
      if (t >= 50) begin n_cmp++; n_bad++; $display("FAIL put_timeout: s_ready stuck low, wanted 1"); end
      @(negedge CLK); s_valid = 0;
   endtask
   initial begin
      logic [31:0] h;
      #1 resetn = 0; b_rstn = 0;
      repeat (2) @(negedge CLK);
      chk("rst_strobe", frame_strobe, 0);
      chk("rst_data", frame_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_done", frames_done, 0);
      chk("rst_ready", s_ready, 1);
      resetn = 1; b_rstn = 1; chk_en = 1;
      @(negedge CLK);
      put(32'hA000_0005); put(32'h1111_1111); put(32'h2222_2222); put(32'h3333_3333); put(32'h4444_4444);
      chk("nom_setup_strobe", frame_strobe, 0);
      @(negedge CLK); chk("nom_strobe1", frame_strobe, 20'h00020);
      @(negedge CLK); chk("nom_strobe2", frame_strobe, 20'h00020);
      @(negedge CLK); chk("nom_hold_strobe", frame_strobe, 0); chk("nom_hold_ready", s_ready, 0);
      @(negedge CLK);
      chk("nom_data", frame_data, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
      chk("nom_done", frames_done, 1);
      chk("nom_err", err, 0);
      chk("nom_ready", s_ready, 1);
      put(32'h5000_0003);
      chk("bad_err", err, 1); chk("bad_busy", busy, 0); chk("bad_strobe", frame_strobe, 0);
      clr_err = 1; @(negedge CLK); clr_err = 0;
      chk("clr_err", err, 0);
      put(32'hA000_0017); put(32'hCAFE_0000); put(32'hCAFE_0001); put(32'hCAFE_0002); put(32'hCAFE_0003);
      repeat (4) @(negedge CLK);
      chk("oor_err", err, 1); chk("oor_done", frames_done, 1);
      chk("oor_data", frame_data, 128'hCAFE_0003_CAFE_0002_CAFE_0001_CAFE_0000);
      clr_err = 1; @(negedge CLK); clr_err = 0;
      rand_clr = 1;
      for (int f = 0; f < 60; f++) begin
         h = {($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hA, 23'($urandom), 5'($urandom)};
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         put(h);
         if (h[31:28] == 4'hA)
            for (int r = 0; r < NR; r++) begin
               repeat ($urandom_range(0, 3)) @(negedge CLK);
               put($urandom);
            end
      end
      rand_clr = 0; clr_err = 0;
      repeat (6) @(negedge CLK);
      put(32'hA000_0003); put(32'h0); put(32'h1); put(32'h2); put(32'h3);
      @(posedge CLK); #1;
      chk("rs_strobe_on", frame_strobe, 20'h00008);
      resetn = 0; #1;
      chk("rs_strobe", frame_strobe, 0);
      chk("rs_data", frame_data, 0);
      @(negedge CLK); resetn = 1;
      @(negedge CLK);
      chk("rs_busy", busy, 0); chk("rs_ready", s_ready, 1);
      b_valid = 1; b_data = 32'hA000_0000; chk("b_ready", b_ready, 1);
      @(negedge CLK); b_data = 32'hDEAD_BEEF; chk("b_load_ready", b_ready, 1);
      @(negedge CLK); b_valid = 0;
      chk("b_setup_strobe", b_fs, 0); chk("b_setup_ready", b_ready, 0);
      @(negedge CLK); chk("b_strobe", b_fs, 20'h00001); chk("b_data", b_fd, 32'hDEAD_BEEF);
      @(negedge CLK); chk("b_hold_strobe", b_fs, 0); chk("b_hold_busy", b_busy, 1);
      @(negedge CLK);
      chk("b_idle_busy", b_busy, 0); chk("b_idle_ready", b_ready, 1);
      chk("b_done", b_done, 1); chk("b_err", b_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Configuration-side writer for the fabric's config latches: accepts a word stream, assembles one configuration frame, then drives the frame-data bus and a one-hot frame strobe.
- The strobe is the latch enable (E) of the addressed latch column; the frame-data bus is the latch D input.
- Sits between the bitstream source (UART/bitbang front end) and the tile array. Its outputs are what the mux select inputs ultimately read.

Parameters:
- NUM_ROWS, 4, number of 32-bit frame-data rows; frame_data width = 32*NUM_ROWS.
- NUM_FRAMES, 20, frames per column; frame_strobe width.
- STROBE_CYCLES, 2, cycles frame_strobe is held high (min 1).
- HDR_MARK, 4'hA, required value of header bits [31:28].

Ports:
- CLK, in, 1, system clock; all logic rising-edge.
- resetn, in, 1, asynchronous active-low reset.
- s_data, in, 32, stream word (header or data).
- s_valid, in, 1, s_data valid.
- s_ready, out, 1, block can accept a word.
- clr_err, in, 1, synchronous clear of err.
- frame_data, out, 32*NUM_ROWS, latch D bus; row r = bits [32r+31:32r].
- frame_strobe, out, NUM_FRAMES, one-hot latch enable.
- busy, out, 1, high in any state except IDLE.
- err, out, 1, sticky error flag.
- frames_done, out, 16, count of successfully strobed frames.

Behaviour:
- Reset (async, resetn=0):
  - State returns to IDLE.
  - frame_strobe=0 immediately; this is required mid-strobe to prevent partial latch writes.
  - frame_data=0, err=0, frames_done=0, busy=0, row counter=0.
- Handshake:
  - A word transfers on a CLK edge with s_valid & s_ready.
  - s_ready = (state==IDLE || state==LOAD), decoded from state only, with no dependence on s_valid.
- IDLE:
  - Accepted word is a header.
  - If [31:28]==HDR_MARK, latch frame index = [4:0] into idx and go to LOAD with row=0.
  - If the marker mismatches, set err, drop the word, and stay in IDLE.
- LOAD:
  - Each accepted word writes row[row]; row increments.
  - The word with row==NUM_ROWS-1 goes to SETUP.
  - Rows not yet overwritten keep prior values; frame_data changes only in LOAD.
- SETUP: one cycle. Data is stable, frame_strobe=0.
- STROBE:
  - STROBE_CYCLES cycles with frame_strobe[idx]=1 and all other bits 0; then HOLD.
  - If idx>=NUM_FRAMES, frame_strobe stays 0, err is set on SETUP entry, and frames_done is not incremented.
- HOLD:
  - One cycle, strobe=0, frame_data unchanged; then IDLE.
  - frames_done increments on HOLD entry for a valid idx, wrapping 16'hFFFF -> 0.
- Latency: last data word accepted at edge T gives:
  - SETUP during cycle T+1.
  - Strobe high cycles T+2 .. T+1+STROBE_CYCLES.
  - HOLD at T+2+STROBE_CYCLES.
  - s_ready=1 again the cycle after HOLD.
- err:
  - Sticky; set-and-clear in the same cycle resolves to set.
  - clr_err has no other effect.
- No timeout: the block waits in LOAD indefinitely for data words.
- frame_strobe is registered (glitch-free). It is never multi-hot and never high while frame_data may change.

Decomposition:
- Shared package cfg_frame_pkg:
  - State enum {IDLE, LOAD, SETUP, STROBE, HOLD}.
  - HDR_MARK position constants (31:28, 4:0).
  - Row word width 32.
- One sub-module, frame_strobe_gen:
  - Takes idx, a start pulse and STROBE_CYCLES.
  - Produces the registered one-hot strobe plus a done pulse; owns the strobe-width counter.
- The FSM and row assembly stay in the top.

Test Plan:
- Nominal frame, defaults:
  - Stimulus: header 32'hA000_0005, then 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444 back-to-back.
  - Response: frame_data=128'h4444_4444_3333_3333_2222_2222_1111_1111; frame_strobe=20'h00020 for exactly 2 cycles starting 2 cycles after the last accept; frames_done=1; err=0.
- Bad marker:
  - Stimulus: header 32'h5000_0003.
  - Response: err=1; state IDLE; no strobe. Then clr_err=1 for one cycle gives err=0.
- Out-of-range index:
  - Stimulus: header 32'hA000_0017 (idx=23) plus 4 data words.
  - Response: frame_data updated; frame_strobe stays 0; err=1; frames_done unchanged.
- Backpressure and gaps:
  - Stimulus: random s_valid gaps during LOAD; s_valid held high through SETUP/STROBE/HOLD.
  - Response: s_ready=0 in those states; no word lost or duplicated; next header accepted the cycle after HOLD.
- Reset mid-strobe:
  - Stimulus: resetn asserted in the first STROBE cycle.
  - Response: frame_strobe=0 combinationally with reset; frame_data=0; after release, busy=0 and s_ready=1.
- STROBE_CYCLES=1, NUM_ROWS=1 build:
  - Stimulus: header 32'hA000_0000, data 32'hDEAD_BEEF.
  - Response: frame_strobe=20'h00001 for exactly 1 cycle; frame_data=32'hDEAD_BEEF.
